// File: rtl/serial_subtractor_4_bit.sv
// Bit-serial 4-bit subtractor: computes A - B - Bin one bit per clock, LSB first.
// A three-state FSM (IDLE/SHIFT/DONE) sequences capture, shifting and the done strobe.
module serial_subtractor_4_bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Bin,
  output logic [3:0] D,
  output logic       Bout,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] res_q, res_d;
  logic [3:0] d_q, d_d;
  logic [1:0] cnt_q, cnt_d;
  logic       br_q, br_d;
  logic       bout_q, bout_d;
  logic       diff_bit;
  logic       br_next;

  // One full-subtractor cell working on the current LSBs.
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 4'b0000;
      b_q     <= 4'b0000;
      res_q   <= 4'b0000;
      d_q     <= 4'b0000;
      cnt_q   <= 2'd0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = 2'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d   = {1'b0, a_q[3:1]};
        b_d   = {1'b0, b_q[3:1]};
        br_d  = br_next;
        res_d = {diff_bit, res_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        // Outputs only update on the final bit so D/Bout stay stable mid-operation.
        if (cnt_q == 2'd3) begin
          d_d     = {diff_bit, res_q[3:1]};
          bout_d  = br_next;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    D    = d_q;
    Bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor_4_bit.sv
// Directed bench for serial_subtractor_4_bit: hand-computed vectors, cycle-exact
// busy/done timing, start-ignore, mid-operation reset and back-to-back operation.
module tb_serial_subtractor_4_bit;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic [3:0] D;
  logic       Bout;
  logic       busy;
  logic       done;

  int n_total;
  int n_bad;
  logic [3:0] prev_d;
  logic       prev_b;

  serial_subtractor_4_bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .D    (D),
    .Bout (Bout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Pulse start for one cycle and follow the operation for six cycles.
  // poke > 0 re-pulses start (with new operands) in that cycle; it must be ignored.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [3:0] exp_d, input logic exp_b, input int poke);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      // Scramble inputs after capture; the operation must not see them.
      A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
      if (i == poke) begin
        start = 1'b1; A = 4'b1111; B = 4'b0000;
      end
      check($sformatf("busy c%0d", i), {7'd0, busy}, {7'd0, (i <= 5)});
      check($sformatf("done c%0d", i), {7'd0, done}, {7'd0, (i == 5)});
      if (i < 5) begin
        check($sformatf("D hold c%0d", i), {4'd0, D}, {4'd0, prev_d});
        check($sformatf("Bout hold c%0d", i), {7'd0, Bout}, {7'd0, prev_b});
      end else begin
        check($sformatf("D c%0d", i), {4'd0, D}, {4'd0, exp_d});
        check($sformatf("Bout c%0d", i), {7'd0, Bout}, {7'd0, exp_b});
      end
    end
    start = 1'b0;
    prev_d = exp_d;
    prev_b = exp_b;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clk_en  = 1'b0;
    rst_n   = 1'b1;
    start   = 1'b0;
    A = 4'd0; B = 4'd0; Bin = 1'b0;

    // Reset with no clock running must act immediately.
    #2 rst_n = 1'b0;
    #1;
    check("rst D", {4'd0, D}, 8'h00);
    check("rst Bout", {7'd0, Bout}, 8'h00);
    check("rst busy", {7'd0, busy}, 8'h00);
    check("rst done", {7'd0, done}, 8'h00);
    prev_d = 4'd0;
    prev_b = 1'b0;

    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", {7'd0, busy}, 8'h00);

    run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 0);
    run_op(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 0);
    run_op(4'b1001, 4'b0110, 1'b1, 4'b0010, 1'b0, 0);
    run_op(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 0);
    run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 0);

    // start re-pulsed mid-SHIFT is ignored and not queued.
    run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("no requeue busy %0d", i), {7'd0, busy}, 8'h00);
      check($sformatf("no requeue done %0d", i), {7'd0, done}, 8'h00);
    end
    check("no requeue D", {4'd0, D}, 8'h02);

    // Reset during SHIFT aborts the operation.
    @(negedge clk);
    A = 4'b1111; B = 4'b0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort D", {4'd0, D}, 8'h00);
    check("abort Bout", {7'd0, Bout}, 8'h00);
    check("abort busy", {7'd0, busy}, 8'h00);
    check("abort done", {7'd0, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    prev_d = 4'd0;
    prev_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("post-abort done %0d", i), {7'd0, done}, 8'h00);
    end
    run_op(4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 0);

    // start held high: one result every 6 cycles, outputs stable between.
    @(negedge clk);
    A = 4'b1001; B = 4'b0110; Bin = 1'b1; start = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      check($sformatf("hold done c%0d", j), {7'd0, done}, {7'd0, (j % 6 == 5)});
      check($sformatf("hold D c%0d", j), {4'd0, D}, 8'h02);
      check($sformatf("hold Bout c%0d", j), {7'd0, Bout}, 8'h00);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("drain busy", {7'd0, busy}, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
